digitron_scan_driver: RTL

//  Multiplexed scan driver for the 6-digit common-anode seven-segment display.

---
 rtl/digitron_scan_driver_if.sv | 21 ++
 rtl/digitron_scan_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/digitron_scan_driver_if.sv
// Control-side bundle for the digitron scan driver: value, DP/blink masks in,
// segment/select pins and status out.
interface digitron_scan_driver_if;
    logic [19:0] number_in;
    logic [5:0]  point_mask;
    logic [5:0]  blink_mask;
    logic [7:0]  seg_n;
    logic [5:0]  sel_n;
    logic        busy;
    logic        ovf;

    modport master (
        output number_in, point_mask, blink_mask,
        input  seg_n, sel_n, busy, ovf
    );

    modport slave (
        input  number_in, point_mask, blink_mask,
        output seg_n, sel_n, busy, ovf
    );
endinterface

// File: rtl/digitron_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver with a sequential double-dabble
// BCD converter. Define DIGITRON_LZB_EN to enable leading-zero blanking.
module digitron_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 2,
    parameter int BLINK_DIV = 83
) (
    input  logic                  clk,
    input  logic                  rst,
    digitron_scan_driver_if.slave bus
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] GHOST_END = SCAN_W'(GHOST_CYC);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_DIV - 1);
    localparam logic [19:0]       MAX_VAL   = 20'd999999;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Scan timing: slot counter, digit index, frame counter, blink phase
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        digit_q, digit_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              slot_wrap;
    logic              frame_wrap;

    assign slot_wrap  = (scan_cnt_q == SCAN_LAST);
    assign frame_wrap = slot_wrap && (digit_q == 3'd5);

    always_comb begin
        scan_cnt_d    = scan_cnt_q + 1'b1;
        digit_d       = digit_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_wrap) begin
            scan_cnt_d = '0;
            digit_d    = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
        end
        if (frame_wrap) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble conversion FSM
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic        init_q, init_d;
    logic [4:0]  shift_cnt_q, shift_cnt_d;
    logic [19:0] bin_q, bin_d;
    logic [23:0] bcd_q, bcd_d;
    logic [23:0] disp_bcd_q, disp_bcd_d;
    logic        ovf_q, ovf_d;
    logic [23:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        shift_cnt_d = shift_cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        disp_bcd_d  = disp_bcd_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                // init_q forces one conversion right after reset so the display
                // does not wait a whole frame for its first value.
                if (init_q || frame_wrap) begin
                    state_d = ST_LOAD;
                    init_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                bin_d       = (bus.number_in > MAX_VAL) ? MAX_VAL : bus.number_in;
                ovf_d       = (bus.number_in > MAX_VAL);
                bcd_d       = '0;
                shift_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[22:0], bin_q, 1'b0};
                shift_cnt_d    = shift_cnt_q + 5'd1;
                if (shift_cnt_q == 5'd19) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                disp_bcd_d = bcd_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit selection, decode and blanking
    // ------------------------------------------------------------------
    logic [3:0] digit_val [6];
    logic [3:0] cur_val;
    logic [6:0] seg_code;
    logic       lzb_blank;
    logic       ghost;
    logic       blink_blank;
    logic [7:0] seg_n_q, seg_n_d;
    logic [5:0] sel_n_q, sel_n_d;

    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign digit_val[gi] = disp_bcd_q[(5-gi)*4 +: 4];
        end
    endgenerate

`ifdef DIGITRON_LZB_EN
    logic [5:0] lead_zero;

    generate
        for (gi = 0; gi < 6; gi++) begin : g_lzb
            if (gi == 0) begin : g_first
                assign lead_zero[gi] = (digit_val[gi] == 4'd0);
            end else begin : g_rest
                assign lead_zero[gi] = lead_zero[gi-1] && (digit_val[gi] == 4'd0);
            end
        end
    endgenerate

    // The units digit is always drawn so a zero value still shows "0".
    assign lzb_blank = (digit_q != 3'd5) && lead_zero[digit_q];
`else
    assign lzb_blank = 1'b0;
`endif

    assign cur_val     = digit_val[digit_q];
    assign ghost       = (scan_cnt_q < GHOST_END);
    assign blink_blank = bus.blink_mask[digit_q] && blink_phase_q;

    always_comb begin
        case (cur_val)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    end

    // Ghost cycles keep every select off while the segment bus settles.
    always_comb begin
        seg_n_d = 8'hFF;
        sel_n_d = 6'h3F;
        if (!ghost) begin
            sel_n_d = ~(6'd1 << digit_q);
            if (!blink_blank) begin
                seg_n_d = {~bus.point_mask[digit_q], lzb_blank ? 7'h7F : seg_code};
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            digit_q       <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= ST_IDLE;
            init_q        <= 1'b1;
            shift_cnt_q   <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            disp_bcd_q    <= '0;
            ovf_q         <= 1'b0;
            seg_n_q       <= 8'hFF;
            sel_n_q       <= 6'h3F;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_q       <= digit_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            init_q        <= init_d;
            shift_cnt_q   <= shift_cnt_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            disp_bcd_q    <= disp_bcd_d;
            ovf_q         <= ovf_d;
            seg_n_q       <= seg_n_d;
            sel_n_q       <= sel_n_d;
        end
    end

    assign bus.seg_n = seg_n_q;
    assign bus.sel_n = sel_n_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.ovf   = ovf_q;

endmodule
